// File: rtl/galvo_dac_sequencer.sv
// rtl/galvo_dac_sequencer.sv - drives one (X, Y) galvo point into two 12-bit I2C DACs
// through the byte engine, with START/STOP framing, NACK/timeout retry and error reporting.
module galvo_dac_sequencer #(
  parameter logic [6:0]  DAC_X_ADDR = 7'h60,
  parameter logic [6:0]  DAC_Y_ADDR = 7'h61,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] pt_x,
  input  logic [11:0] pt_y,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  byte_data,
  output logic        byte_start,
  output logic        byte_stop,
  output logic        byte_go,
  output logic        bus_abort,
  input  logic        byte_done,
  input  logic        byte_nack,
  output logic        busy,
  output logic        err,
  output logic        err_axis,
  output logic [15:0] pt_count
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  // Byte states are consecutive so the success path simply steps to state + 1.
  typedef enum logic [3:0] {IDLE, XA, XH, XL, YA, YH, YL, DONE, ABORT} state_t;

  state_t        state;
  state_t        nxt;
  logic [11:0]   x_q;
  logic [11:0]   y_q;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo;
  logic          abort_axis;
  logic          is_y;

  assign nxt  = state_t'(state + 4'd1);
  assign is_y = (state == YA) || (state == YH) || (state == YL);

  // {byte_start, byte_stop, byte_data} for each byte state.
  function automatic logic [9:0] byte_for(input state_t s, input logic [11:0] x,
                                          input logic [11:0] y);
    case (s)
      XA:      byte_for = {2'b10, DAC_X_ADDR, 1'b0};
      XH:      byte_for = {2'b00, 4'h0, x[11:8]};
      XL:      byte_for = {2'b01, x[7:0]};
      YA:      byte_for = {2'b10, DAC_Y_ADDR, 1'b0};
      YH:      byte_for = {2'b00, 4'h0, y[11:8]};
      YL:      byte_for = {2'b01, y[7:0]};
      default: byte_for = 10'h000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pt_ready   <= 1'b0;
      byte_go    <= 1'b0;
      bus_abort  <= 1'b0;
      byte_start <= 1'b0;
      byte_stop  <= 1'b0;
      byte_data  <= 8'h00;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_axis   <= 1'b0;
      pt_count   <= 16'h0000;
      retry      <= '0;
      tmo        <= '0;
      abort_axis <= 1'b0;
      x_q        <= 12'h000;
      y_q        <= 12'h000;
    end else begin
      byte_go   <= 1'b0;
      bus_abort <= 1'b0;
      case (state)
        IDLE: begin
          retry <= '0;
          if (pt_valid && pt_ready) begin
            x_q      <= pt_x;
            y_q      <= pt_y;
            err      <= 1'b0;
            pt_ready <= 1'b0;
            busy     <= 1'b1;
            tmo      <= '0;
            state    <= XA;
            byte_go  <= 1'b1;
            {byte_start, byte_stop, byte_data} <= byte_for(XA, pt_x, pt_y);
          end else begin
            pt_ready <= 1'b1;
          end
        end
        XA, XH, XL, YA, YH, YL: begin
          // A done in the strobe cycle cannot belong to this byte, so it is ignored.
          if (!byte_go && byte_done && !byte_nack) begin
            tmo   <= '0;
            state <= nxt;
            if (nxt != DONE) begin
              byte_go <= 1'b1;
              {byte_start, byte_stop, byte_data} <= byte_for(nxt, x_q, y_q);
            end
            if (state == XL) retry <= '0;
          end else if ((!byte_go && byte_done) || tmo == TMO_LAST) begin
            state      <= ABORT;
            bus_abort  <= 1'b1;
            tmo        <= '0;
            abort_axis <= is_y;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ABORT: begin
          if ((!bus_abort && byte_done) || tmo == TMO_LAST) begin
            tmo <= '0;
            if (retry < RETRY_MAX) begin
              retry   <= retry + 1'b1;
              state   <= abort_axis ? YA : XA;
              byte_go <= 1'b1;
              {byte_start, byte_stop, byte_data} <= byte_for(abort_axis ? YA : XA, x_q, y_q);
            end else begin
              err      <= 1'b1;
              err_axis <= abort_axis;
              state    <= DONE;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          if (!err) pt_count <= pt_count + 16'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_galvo_dac_sequencer.sv
// tb/tb_galvo_dac_sequencer.sv - scoreboard bench for galvo_dac_sequencer with a
// behavioural byte engine (single-cycle, NACK and hang injection).
module tb_galvo_dac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] pt_x = 12'h000;
  logic [11:0] pt_y = 12'h000;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [7:0]  byte_data;
  logic        byte_start;
  logic        byte_stop;
  logic        byte_go;
  logic        bus_abort;
  logic        byte_done = 1'b0;
  logic        byte_nack = 1'b0;
  logic        busy;
  logic        err;
  logic        err_axis;
  logic [15:0] pt_count;

  galvo_dac_sequencer #(
    .DAC_X_ADDR(7'h60),
    .DAC_Y_ADDR(7'h61),
    .MAX_RETRY (2),
    .TIMEOUT   (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .byte_data (byte_data),
    .byte_start(byte_start),
    .byte_stop (byte_stop),
    .byte_go   (byte_go),
    .bus_abort (bus_abort),
    .byte_done (byte_done),
    .byte_nack (byte_nack),
    .busy      (busy),
    .err       (err),
    .err_axis  (err_axis),
    .pt_count  (pt_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          go_cyc = 0;
  int          abort_gap = 0;
  int          aborts = 0;
  logic [9:0]  exp_q[$];
  logic [15:0] exp_count = 16'h0000;
  bit          nack_x_all = 0;
  bit          nack_y_once = 0;
  bit          hang_xh_once = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic s, input logic p, input logic [7:0] d);
    return {s, p, d};
  endfunction

  task automatic push_pt(input logic [11:0] x, input logic [11:0] y);
    exp_q.push_back(mk(1, 0, 8'hC0));
    exp_q.push_back(mk(0, 0, {4'h0, x[11:8]}));
    exp_q.push_back(mk(0, 1, x[7:0]));
    exp_q.push_back(mk(1, 0, 8'hC2));
    exp_q.push_back(mk(0, 0, {4'h0, y[11:8]}));
    exp_q.push_back(mk(0, 1, y[7:0]));
  endtask

  // Byte engine model plus scoreboard; responds one cycle after each command.
  initial begin
    bit         pend = 0;
    bit         pend_nack = 0;
    bit         nk;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      byte_done = 0;
      byte_nack = 0;
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          byte_done = 1;
          byte_nack = pend_nack;
          pend = 0;
        end
        if (pt_valid && pt_ready) check("accept_while_busy", busy, 0);
        if (bus_abort) begin
          aborts++;
          abort_gap = cyc - go_cyc;
          pend = 1;
          pend_nack = 0;
        end
        if (byte_go) begin
          go_cyc = cyc;
          check("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte", {byte_start, byte_stop, byte_data}, e);
          end
          nk = (nack_x_all && byte_start && byte_data == 8'hC0) ||
               (nack_y_once && byte_start && byte_data == 8'hC2);
          if (nack_y_once && byte_start && byte_data == 8'hC2) nack_y_once = 0;
          if (hang_xh_once && !byte_start && !byte_stop && byte_data == 8'h0A) begin
            hang_xh_once = 0;
          end else begin
            pend = 1;
            pend_nack = nk;
          end
        end
      end
    end
  end

  task automatic send_point(input logic [11:0] x, input logic [11:0] y);
    int n = 0;
    while (!pt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", pt_ready, 1);
    pt_x = x;
    pt_y = y;
    pt_valid = 1;
    @(negedge clk);
    pt_valid = 0;
    acc_cyc = cyc;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pt_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_return", pt_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int n;
    int k;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {pt_ready, byte_go, bus_abort, byte_start, byte_stop, busy, err, err_axis, byte_data},
          0);
    check("reset_count", pt_count, 0);
    reset_n = 1;
    @(negedge clk);
    check("ready_after_reset", pt_ready, 1);

    // Nominal point
    push_pt(12'hABC, 12'h123);
    send_point(12'hABC, 12'h123);
    check("busy_after_accept", busy, 1);
    wait_ready();
    check("latency_to_ready", cyc - acc_cyc, 14);
    exp_count = exp_count + 16'd1;
    check("nominal_count", pt_count, exp_count);
    check("nominal_err", err, 0);
    check("nominal_drain", exp_q.size(), 0);

    // NACK on first Y address, single retry of Y only
    a0 = aborts;
    nack_y_once = 1;
    exp_q.push_back(mk(1, 0, 8'hC0));
    exp_q.push_back(mk(0, 0, 8'h05));
    exp_q.push_back(mk(0, 1, 8'h55));
    exp_q.push_back(mk(1, 0, 8'hC2));
    exp_q.push_back(mk(1, 0, 8'hC2));
    exp_q.push_back(mk(0, 0, 8'h0A));
    exp_q.push_back(mk(0, 1, 8'hAA));
    send_point(12'h555, 12'hAAA);
    wait_ready();
    exp_count = exp_count + 16'd1;
    check("nack_aborts", aborts - a0, 1);
    check("nack_count", pt_count, exp_count);
    check("nack_err", err, 0);
    check("nack_drain", exp_q.size(), 0);

    // Retry exhaustion on X address
    a0 = aborts;
    nack_x_all = 1;
    repeat (3) exp_q.push_back(mk(1, 0, 8'hC0));
    send_point(12'h321, 12'h654);
    wait_ready();
    nack_x_all = 0;
    check("exhaust_aborts", aborts - a0, 3);
    check("exhaust_err", err, 1);
    check("exhaust_axis", err_axis, 0);
    check("exhaust_count", pt_count, exp_count);
    check("exhaust_drain", exp_q.size(), 0);

    // Engine hangs after XH once; abort after TIMEOUT, retry from XA
    a0 = aborts;
    hang_xh_once = 1;
    exp_q.push_back(mk(1, 0, 8'hC0));
    exp_q.push_back(mk(0, 0, 8'h0A));
    push_pt(12'hABC, 12'h123);
    send_point(12'hABC, 12'h123);
    check("err_cleared_on_accept", err, 0);
    wait_ready();
    exp_count = exp_count + 16'd1;
    check("timeout_gap", abort_gap, 20);
    check("timeout_aborts", aborts - a0, 1);
    check("timeout_count", pt_count, exp_count);
    check("timeout_drain", exp_q.size(), 0);

    // Reset during YH
    a0 = aborts;
    push_pt(12'h456, 12'h789);
    send_point(12'h456, 12'h789);
    n = 0;
    while (!(byte_go && !byte_start && byte_data == 8'h07) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_yh", byte_go && !byte_start && byte_data == 8'h07, 1);
    reset_n = 0;
    @(negedge clk);
    check("midreset_outputs",
          {pt_ready, byte_go, bus_abort, byte_start, byte_stop, busy, err, err_axis, byte_data},
          0);
    check("midreset_count", pt_count, 0);
    exp_q.delete();
    reset_n = 1;
    exp_count = 16'h0000;
    @(negedge clk);
    check("midreset_no_abort", aborts - a0, 0);
    push_pt(12'h456, 12'h789);
    send_point(12'h456, 12'h789);
    wait_ready();
    exp_count = exp_count + 16'd1;
    check("after_reset_count", pt_count, exp_count);
    check("after_reset_drain", exp_q.size(), 0);

    // Back-to-back with pt_valid held high
    repeat (3) push_pt(12'h0F0, 12'hF0F);
    pt_x = 12'h0F0;
    pt_y = 12'hF0F;
    pt_valid = 1;
    n = 0;
    k = 0;
    while (n < 3 && k < 200) begin
      if (pt_ready) n++;
      @(negedge clk);
      k++;
    end
    pt_valid = 0;
    check("b2b_accepts", n, 3);
    wait_ready();
    exp_count = exp_count + 16'd3;
    check("b2b_count", pt_count, exp_count);
    check("b2b_drain", exp_q.size(), 0);

    // Counter wrap
    force dut.pt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pt_count;
    exp_count = 16'hFFFF;
    push_pt(12'h001, 12'hFFE);
    send_point(12'h001, 12'hFFE);
    wait_ready();
    exp_count = exp_count + 16'd1;
    check("wrap_count", pt_count, exp_count);
    check("wrap_drain", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
